// File: rtl/four_bit_serial_subtractor.sv
// Two-slice serial subtractor: d = a - b - bin, low 2-bit slice then high 2-bit slice,
// with the inter-slice borrow held in a register and a start/busy/done handshake.
module four_bit_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] d,
  output logic       bout,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] d_q, d_d;
  logic       brw_q, brw_d;
  logic       bout_q, bout_d;
  logic       ovf_q, ovf_d;

  logic [2:0] slice_lo;
  logic [2:0] slice_hi;
  logic       accept;

  // Each slice yields {borrow, diff[1:0]}; bit 2 is set whenever the slice result went negative.
  assign slice_lo = {1'b0, a_q[1:0]} - {1'b0, b_q[1:0]} - {2'b00, brw_q};
  assign slice_hi = {1'b0, a_q[3:2]} - {1'b0, b_q[3:2]} - {2'b00, brw_q};

  assign accept = start & ((state_q == IDLE) | (state_q == DONE));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          // The borrow register first holds bin, then the borrow out of the low slice.
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          state_d = LOW;
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        d_d[1:0] = slice_lo[1:0];
        brw_d    = slice_lo[2];
        state_d  = HIGH;
      end
      HIGH: begin
        d_d[3:2] = slice_hi[1:0];
        bout_d   = slice_hi[2];
        ovf_d    = (a_q[3] != b_q[3]) & (slice_hi[1] != a_q[3]);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 4'b0000;
      b_q     <= 4'b0000;
      d_q     <= 4'b0000;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == LOW) | (state_q == HIGH);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Self-checking bench for four_bit_serial_subtractor: directed cases from the test plan plus
// randomized operations compared against an arithmetic reference model.
module tb_four_bit_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bout;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] prev_d;
  logic       prev_bout;
  logic       prev_ovf;

  four_bit_serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole 4-bit operands.
  task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic mbin,
                       output logic [3:0] ed, output logic eb, output logic eo);
    int diff;
    int sa;
    int sb;
    int s;
    diff = int'(ma) - int'(mb) - int'(mbin);
    ed   = 4'((diff + 32) % 16);
    eb   = (diff < 0);
    sa   = (ma >= 8) ? int'(ma) - 16 : int'(ma);
    sb   = (mb >= 8) ? int'(mb) - 16 : int'(mb);
    s    = sa - sb - int'(mbin);
    eo   = (s < -8) || (s > 7);
  endtask

  // Called at a negedge while the DUT is IDLE or DONE; the next posedge accepts.
  task automatic start_op(input logic [3:0] oa, input logic [3:0] ob, input logic obin);
    start = 1'b1;
    a     = oa;
    b     = ob;
    bin   = obin;
    @(negedge clk);
  endtask

  // Called at the negedge inside LOW; walks LOW, HIGH, DONE and checks each phase.
  // Operand inputs and start are scrambled while busy to show they are ignored.
  task automatic finish_op(input string tag, input logic [3:0] oa, input logic [3:0] ob,
                           input logic obin);
    logic [3:0] ed;
    logic       eb;
    logic       eo;
    model(oa, ob, obin, ed, eb, eo);
    check({tag, " low busy"}, busy, 1);
    check({tag, " low done"}, done, 0);
    check({tag, " low d hold"}, d, prev_d);
    check({tag, " low bout hold"}, bout, prev_bout);
    start = 1'($urandom);
    a     = 4'($urandom);
    b     = 4'($urandom);
    bin   = 1'($urandom);
    @(negedge clk);
    check({tag, " high busy"}, busy, 1);
    check({tag, " high done"}, done, 0);
    check({tag, " high d lo"}, d[1:0], ed[1:0]);
    check({tag, " high d hi hold"}, d[3:2], prev_d[3:2]);
    start = 1'($urandom);
    a     = 4'($urandom);
    b     = 4'($urandom);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1);
    check({tag, " done busy"}, busy, 0);
    check({tag, " d"}, d, ed);
    check({tag, " bout"}, bout, eb);
    check({tag, " ovf"}, ovf, eo);
    prev_d    = ed;
    prev_bout = eb;
    prev_ovf  = eo;
    start     = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    @(negedge clk);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle done"}, done, 0);
    check({tag, " idle d hold"}, d, prev_d);
    check({tag, " idle ovf hold"}, ovf, prev_ovf);
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rbin;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    bin       = 1'b0;
    prev_d    = 4'd0;
    prev_bout = 1'b0;
    prev_ovf  = 1'b0;

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset d", d, 0);
    check("reset bout", bout, 0);
    check("reset ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    go_idle("post reset");

    start_op(4'd7, 4'd3, 1'b0);
    finish_op("7-3", 4'd7, 4'd3, 1'b0);
    go_idle("7-3");

    start_op(4'd2, 4'd5, 1'b0);
    finish_op("2-5", 4'd2, 4'd5, 1'b0);
    go_idle("2-5");

    start_op(4'd8, 4'd1, 1'b0);
    finish_op("8-1", 4'd8, 4'd1, 1'b0);
    go_idle("8-1");

    start_op(4'd0, 4'd0, 1'b1);
    finish_op("0-0-1", 4'd0, 4'd0, 1'b1);

    // Back-to-back: issued from DONE, so done pulses land 3 cycles apart.
    start_op(4'd15, 4'd15, 1'b0);
    finish_op("b2b 15-15", 4'd15, 4'd15, 1'b0);
    start_op(4'd4, 4'd9, 1'b1);
    finish_op("b2b 4-9-1", 4'd4, 4'd9, 1'b1);
    go_idle("b2b");

    // Reset during HIGH clears outputs asynchronously, before any clock edge.
    start_op(4'd13, 4'd6, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check("rst mid busy before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid busy", busy, 0);
    check("rst mid done", done, 0);
    check("rst mid d", d, 0);
    check("rst mid bout", bout, 0);
    check("rst mid ovf", ovf, 0);
    @(negedge clk);
    check("rst held no done", done, 0);
    prev_d    = 4'd0;
    prev_bout = 1'b0;
    prev_ovf  = 1'b0;
    // Release with start already high: accepted at the first rising edge.
    rst_n = 1'b1;
    start_op(4'd1, 4'd1, 1'b0);
    finish_op("after rst 1-1", 4'd1, 4'd1, 1'b0);
    go_idle("after rst");

    for (int i = 0; i < 24; i++) begin
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      rbin = 1'($urandom);
      start_op(ra, rb, rbin);
      finish_op($sformatf("rand%0d", i), ra, rb, rbin);
      if ($urandom_range(1, 0) == 0) go_idle($sformatf("rand%0d", i));
    end
    go_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
